// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding ifetch, mini-decoder hookup, static next-PC prediction,
// IR-stage handoff and EXU flush redirect with drop of an in-flight response.
module ifu_fetch_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [PC_W-1:0] ifu_req_pc,
  input  logic            ifu_rsp_valid,
  output logic            ifu_rsp_ready,
  input  logic [31:0]     ifu_rsp_instr,
  output logic [31:0]     mdec_instr,
  input  logic            mdec_jal,
  input  logic            mdec_jalr,
  input  logic            mdec_bxx,
  input  logic [4:0]      mdec_jalr_rs1idx,
  input  logic [31:0]     mdec_bjp_imm,
  input  logic [31:0]     jalr_rs1_val,
  input  logic            jalr_rs1_rdy,
  output logic            jalr_rs1_req,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [31:0]     ir_instr,
  output logic [PC_W-1:0] ir_pc,
  output logic            ir_prdt_taken,
  input  logic            flush_req,
  input  logic [PC_W-1:0] flush_pc,
  output logic            flush_ack,
  output logic [2:0]      o_dbg_state,
  output logic            o_dbg_discard
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid is never
  // withdrawn and its payload never changes until that transfer, except when a flush cancels it.
  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_DEC   = 3'd2,
    S_JWAIT = 3'd3,
    S_OUT   = 3'd4,
    S_DROP  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_ir_pc;
  logic [PC_W-1:0] r_next_pc;
  logic [31:0]     r_instr;
  logic            r_prdt_taken;
  logic            r_discard;

  logic            w_ir_fire;
  logic            w_rsp_take;
  logic            w_jalr_dep;
  logic            w_pred_latch;
  logic            w_bxx_taken;
  logic            w_taken;
  logic [PC_W-1:0] w_imm;
  logic [PC_W-1:0] w_rs1;
  logic [PC_W-1:0] w_jalr_sum;
  logic [PC_W-1:0] w_pred_pc;

  assign w_ir_fire    = (r_state == S_OUT) && ir_ready && !flush_req;
  assign w_rsp_take   = (r_state == S_WAIT) && ifu_rsp_valid && !flush_req;
  assign w_jalr_dep   = mdec_jalr && (mdec_jalr_rs1idx != 5'd0);
  assign w_pred_latch = !flush_req &&
                        (((r_state == S_DEC) && !w_jalr_dep) ||
                         ((r_state == S_JWAIT) && jalr_rs1_rdy));

  // Static prediction: jumps always taken, conditional branches taken only when backward.
  assign w_imm       = PC_W'($signed(mdec_bjp_imm));
  assign w_rs1       = (mdec_jalr_rs1idx == 5'd0) ? '0 : PC_W'(jalr_rs1_val);
  assign w_jalr_sum  = w_rs1 + w_imm;
  assign w_bxx_taken = mdec_bxx && mdec_bjp_imm[31];
  assign w_taken     = mdec_jal || w_bxx_taken || mdec_jalr;

  always_comb begin
    w_pred_pc = r_ir_pc + PC_W'(4);
    if (mdec_jal || w_bxx_taken) begin
      w_pred_pc = r_ir_pc + w_imm;
    end else if (mdec_jalr) begin
      w_pred_pc = {w_jalr_sum[PC_W-1:1], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush_req) begin
      // A fetch still owed by the bus must be dropped; one arriving in the flush cycle itself is already gone.
      case (r_state)
        S_REQ:   w_next_state = ifu_req_ready ? S_DROP : S_REQ;
        S_WAIT:  w_next_state = ifu_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  w_next_state = ifu_rsp_valid ? S_REQ : S_DROP;
        default: w_next_state = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ:   if (ifu_req_ready) w_next_state = S_WAIT;
        S_WAIT:  if (ifu_rsp_valid) w_next_state = S_DEC;
        S_DEC:   w_next_state = w_jalr_dep ? S_JWAIT : S_OUT;
        S_JWAIT: if (jalr_rs1_rdy) w_next_state = S_OUT;
        S_OUT:   if (ir_ready) w_next_state = S_REQ;
        S_DROP:  if (ifu_rsp_valid) w_next_state = S_REQ;
        default: w_next_state = S_REQ;
      endcase
    end
  end

  always_comb begin
    ifu_req_valid = rst_n && (r_state == S_REQ);
    ifu_req_pc    = r_pc;
    ifu_rsp_ready = (r_state == S_WAIT) || (r_state == S_DROP);
    jalr_rs1_req  = (r_state == S_JWAIT);
    ir_valid      = (r_state == S_OUT) && !flush_req;
    flush_ack     = rst_n && flush_req;
    mdec_instr    = r_instr;
    ir_instr      = r_instr;
    ir_pc         = r_ir_pc;
    ir_prdt_taken = r_prdt_taken;
    o_dbg_state   = r_state;
    o_dbg_discard = r_discard;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_ir_pc      <= '0;
      r_next_pc    <= '0;
      r_instr      <= '0;
      r_prdt_taken <= 1'b0;
      r_discard    <= 1'b0;
    end else begin
      r_discard <= (w_next_state == S_DROP);
      if (flush_req) begin
        r_pc <= flush_pc;
      end else if (w_ir_fire) begin
        r_pc <= r_next_pc;
      end
      if (w_rsp_take) begin
        r_instr <= ifu_rsp_instr;
        r_ir_pc <= r_pc;
      end
      if (w_pred_latch) begin
        r_next_pc    <= w_pred_pc;
        r_prdt_taken <= w_taken;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: table of fetched instructions with expected PC flow, a behavioural mini-decoder,
// plus hand-written flush / drop / reset sequences.
module tb_ifu_fetch_ctrl;

  localparam int          W   = 65;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr;
  logic [31:0] mdec_instr;
  logic        mdec_jal;
  logic        mdec_jalr;
  logic        mdec_bxx;
  logic [4:0]  mdec_jalr_rs1idx;
  logic [31:0] mdec_bjp_imm;
  logic [31:0] jalr_rs1_val;
  logic        jalr_rs1_rdy;
  logic        jalr_rs1_req;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_instr;
  logic [31:0] ir_pc;
  logic        ir_prdt_taken;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        flush_ack;
  logic [2:0]  o_dbg_state;
  logic        o_dbg_discard;

  int n_checks;
  int n_errors;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    int          rs1_wait;
    logic        jw;
    logic        taken;
    int          stall;
    logic        do_flush;
    logic [31:0] flush_pc;
  } vec_t;

  vec_t tbl[12];

  ifu_fetch_ctrl #(.PC_W(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
    .mdec_instr(mdec_instr), .mdec_jal(mdec_jal), .mdec_jalr(mdec_jalr), .mdec_bxx(mdec_bxx),
    .mdec_jalr_rs1idx(mdec_jalr_rs1idx), .mdec_bjp_imm(mdec_bjp_imm),
    .jalr_rs1_val(jalr_rs1_val), .jalr_rs1_rdy(jalr_rs1_rdy), .jalr_rs1_req(jalr_rs1_req),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_pc(ir_pc),
    .ir_prdt_taken(ir_prdt_taken),
    .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(flush_ack),
    .o_dbg_state(o_dbg_state), .o_dbg_discard(o_dbg_discard)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- mini-decoder model (RV32 jal/jalr/branch) ----------------
  always_comb begin
    mdec_jal         = (mdec_instr[6:0] == 7'h6f);
    mdec_jalr        = (mdec_instr[6:0] == 7'h67);
    mdec_bxx         = (mdec_instr[6:0] == 7'h63);
    mdec_jalr_rs1idx = mdec_instr[19:15];
    mdec_bjp_imm     = 32'h0;
    if (mdec_jal)
      mdec_bjp_imm = {{12{mdec_instr[31]}}, mdec_instr[19:12], mdec_instr[20], mdec_instr[30:21], 1'b0};
    else if (mdec_bxx)
      mdec_bjp_imm = {{20{mdec_instr[31]}}, mdec_instr[7], mdec_instr[30:25], mdec_instr[11:8], 1'b0};
    else if (mdec_jalr)
      mdec_bjp_imm = {{20{mdec_instr[31]}}, mdec_instr[31:20]};
  end

  function automatic logic [31:0] enc_jal(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, 5'd1, 7'h67};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!ifu_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_valid", 72'(ifu_req_valid), 72'd1);
  endtask

  // ---------------- driver: one complete fetch through the IR handoff ----------------
  task automatic fetch_one(input vec_t v);
    int n;
    int k;
    int rs1_req_cnt;
    logic req_seen;
    logic [W-1:0] exp;
    wait_req();
    check("req_pc", 72'(ifu_req_pc), 72'(v.pc));
    ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu_req_ready = 1'b0;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      check("wait_state", 72'({ifu_req_valid, ifu_rsp_ready}), 72'b01);
      @(negedge clk);
    end
    check("rsp_ready", 72'(ifu_rsp_ready), 72'd1);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = v.instr;
    jalr_rs1_val  = v.rs1_val;
    jalr_rs1_rdy  = 1'b0;
    exp_q.push_back({v.instr, v.pc, v.taken});
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    ifu_rsp_instr = $urandom();
    check("mdec_instr", 72'(mdec_instr), 72'(v.instr));
    k = 0;
    rs1_req_cnt = 0;
    req_seen = 1'b0;
    while (!ir_valid && k < 40) begin
      req_seen |= ifu_req_valid;
      rs1_req_cnt += int'(jalr_rs1_req);
      jalr_rs1_rdy = (k > v.rs1_wait);
      @(negedge clk);
      k++;
    end
    check("ir_valid", 72'(ir_valid), 72'd1);
    check("no_req_in_flight", 72'(req_seen), 72'd0);
    check("latency", 72'(k), 72'(v.jw ? v.rs1_wait + 2 : 1));
    check("rs1_req_cycles", 72'(rs1_req_cnt), 72'(v.jw ? v.rs1_wait + 1 : 0));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("ir_data", 72'({ir_instr, ir_pc, ir_prdt_taken}), 72'(exp));
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      check("stall_hold", 72'({ir_valid, ifu_req_valid, ir_instr, ir_pc, ir_prdt_taken}), 72'({2'b10, exp}));
    end
    ir_ready = 1'b1;
    if (v.do_flush) begin
      flush_req = 1'b1;
      flush_pc  = v.flush_pc;
      #1;
      check("flush_ack_out", 72'(flush_ack), 72'd1);
      check("flush_masks_ir", 72'(ir_valid), 72'd0);
    end
    @(negedge clk);
    ir_ready  = 1'b0;
    flush_req = 1'b0;
    check("ir_released", 72'(ir_valid), 72'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_instr = 32'h0;
    jalr_rs1_val = 32'h0;
    jalr_rs1_rdy = 1'b0;
    ir_ready = 1'b0;
    flush_req = 1'b0;
    flush_pc = 32'h0;

    tbl[0]  = '{32'h8000_0000, NOP, 32'h0, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0};
    tbl[1]  = '{32'h8000_0004, NOP, 32'h0, 0, 1'b0, 1'b0, 2, 1'b0, 32'h0};
    tbl[2]  = '{32'h8000_0008, NOP, 32'h0, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0};
    tbl[3]  = '{32'h8000_000c, enc_jal(32'h14), 32'h0, 0, 1'b0, 1'b1, 0, 1'b0, 32'h0};
    tbl[4]  = '{32'h8000_0020, enc_beq(32'h8), 32'h0, 0, 1'b0, 1'b0, 1, 1'b0, 32'h0};
    tbl[5]  = '{32'h8000_0024, enc_jal(32'hffff_fffc), 32'h0, 0, 1'b0, 1'b1, 0, 1'b0, 32'h0};
    tbl[6]  = '{32'h8000_0020, enc_beq(32'hffff_fff8), 32'h0, 0, 1'b0, 1'b1, 0, 1'b0, 32'h0};
    tbl[7]  = '{32'h8000_0018, enc_jalr(5'd5, 12'h003), 32'h8000_1000, 4, 1'b1, 1'b1, 0, 1'b0, 32'h0};
    tbl[8]  = '{32'h8000_1002, enc_jalr(5'd0, 12'h100), 32'h1234_5678, 0, 1'b0, 1'b1, 0, 1'b0, 32'h0};
    tbl[9]  = '{32'h0000_0100, enc_jalr(5'd6, 12'h020), 32'hffff_fff0, 0, 1'b1, 1'b1, 0, 1'b0, 32'h0};
    tbl[10] = '{32'h0000_0010, enc_jal(32'h10), 32'h0, 0, 1'b0, 1'b1, 5, 1'b1, 32'h8000_5000};
    tbl[11] = '{32'h8000_5000, NOP, 32'h0, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0};

    repeat (3) @(negedge clk);
    check("rst_ctrl_outs", 72'({ifu_req_valid, ifu_rsp_ready, ir_valid, jalr_rs1_req, flush_ack, o_dbg_discard}), 72'd0);
    check("rst_req_pc", 72'(ifu_req_pc), 72'h8000_0000);
    check("rst_ir_data", 72'({ir_instr, ir_pc, ir_prdt_taken}), 72'd0);
    check("rst_mdec_instr", 72'(mdec_instr), 72'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) fetch_one(tbl[i]);

    // Flush while waiting for the response: the late response is dropped.
    wait_req();
    check("a_req_pc", 72'(ifu_req_pc), 72'h8000_5004);
    ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu_req_ready = 1'b0;
    flush_req = 1'b1;
    flush_pc  = 32'h8000_2000;
    #1;
    check("a_flush_ack", 72'(flush_ack), 72'd1);
    @(negedge clk);
    flush_req = 1'b0;
    #1;
    check("a_ack_pulse", 72'(flush_ack), 72'd0);
    check("a_drop_state", 72'({ifu_req_valid, ifu_rsp_ready, o_dbg_discard}), 72'b011);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = enc_jal(32'h40);
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    check("a_after_drop", 72'({ir_valid, ifu_req_valid, o_dbg_discard}), 72'b010);
    check("a_redirect_pc", 72'(ifu_req_pc), 72'h8000_2000);
    fetch_one('{32'h8000_2000, NOP, 32'h0, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0});

    // Flush coinciding with a request fire, then a second flush while dropping.
    wait_req();
    check("b_req_pc", 72'(ifu_req_pc), 72'h8000_2004);
    ifu_req_ready = 1'b1;
    flush_req = 1'b1;
    flush_pc  = 32'h8000_3000;
    #1;
    check("b_flush_ack", 72'(flush_ack), 72'd1);
    @(negedge clk);
    ifu_req_ready = 1'b0;
    flush_pc = 32'h8000_3100;
    #1;
    check("b_drop_state", 72'({ifu_req_valid, ifu_rsp_ready, flush_ack}), 72'b011);
    @(negedge clk);
    flush_req = 1'b0;
    check("b_still_drop", 72'({ifu_req_valid, ifu_rsp_ready, o_dbg_discard}), 72'b011);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = NOP;
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    check("b_after_drop", 72'({ir_valid, ifu_req_valid}), 72'b01);
    check("b_redirect_pc", 72'(ifu_req_pc), 72'h8000_3100);

    // Flush in REQ without a fire: the request is simply re-aimed.
    flush_req = 1'b1;
    flush_pc  = 32'h8000_4000;
    @(negedge clk);
    flush_req = 1'b0;
    check("c_reissue", 72'({ifu_req_valid, ifu_rsp_ready}), 72'b10);
    check("c_req_pc", 72'(ifu_req_pc), 72'h8000_4000);
    fetch_one('{32'h8000_4000, NOP, 32'h0, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0});

    // Reset with a fetch in flight, then a stray response before any request.
    wait_req();
    check("r_req_pc", 72'(ifu_req_pc), 72'h8000_4004);
    ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("r_ctrl_outs", 72'({ifu_req_valid, ifu_rsp_ready, ir_valid, jalr_rs1_req, o_dbg_state}), 72'd0);
    check("r_pc_data", 72'({ifu_req_pc, ir_pc, ir_instr}), 72'({32'h8000_0000, 32'h0, 32'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = enc_jal(32'h80);
    #1;
    check("r_no_rsp_accept", 72'({ifu_rsp_ready, ifu_req_valid}), 72'b01);
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    check("r_still_req", 72'(o_dbg_state), 72'd0);
    fetch_one(tbl[0]);

    check("scoreboard_empty", 72'(exp_q.size()), 72'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
